// File: rtl/norm_factor_gen.sv
// Per-frame normalisation factor: floor(2^FRAC_WIDTH / (frame_max + 1)) via a restoring divider.
// Optional build macro NORM_FACTOR_GEN_OVERRUN_CNT_EN adds a saturating dropped-frame counter.
module norm_factor_gen #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INT_WIDTH-1:0]  pixel,
   input  logic                  pixel_tvalid,
   input  logic                  pixel_tlast,
   output logic [FRAC_WIDTH-1:0] norm_factor,
   output logic                  norm_factor_tvalid,
   output logic [INT_WIDTH-1:0]  frame_max,
   output logic                  overrun,
   output logic [15:0]           overrun_count
);

   localparam int DW = INT_WIDTH + 1;
   localparam int CW = $clog2(FRAC_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t                state_q,   state_d;
   logic [INT_WIDTH-1:0]  run_max_q, run_max_d;
   logic [INT_WIDTH-1:0]  max_lat_q, max_lat_d;
   logic [DW-1:0]         div_q,     div_d;
   logic [DW-1:0]         rem_q,     rem_d;
   logic [FRAC_WIDTH:0]   quo_q,     quo_d;
   logic [CW-1:0]         cnt_q,     cnt_d;
   logic [FRAC_WIDTH-1:0] nf_q,      nf_d;
   logic [INT_WIDTH-1:0]  fm_q,      fm_d;
   logic                  nfv_q,     nfv_d;
   logic                  ovr_q,     ovr_d;

   logic [INT_WIDTH-1:0]  beat_max_s;
   logic                  eof_s;
   logic                  accept_s;
   logic                  drop_s;
   logic [DW:0]           rem_shift_s;
   logic [DW:0]           rem_diff_s;
   logic                  sub_ok_s;
   logic [DW-1:0]         rem_next_s;

   assign beat_max_s = (pixel > run_max_q) ? pixel : run_max_q;
   assign eof_s      = pixel_tvalid & pixel_tlast;
   assign accept_s   = eof_s & (state_q != S_DIV);
   assign drop_s     = eof_s & (state_q == S_DIV);

   // Dividend is 2^FRAC_WIDTH, so only the first quotient step shifts in a one.
   assign rem_shift_s = {rem_q, (cnt_q == {CW{1'b0}})};
   assign rem_diff_s  = rem_shift_s - {1'b0, div_q};
   assign sub_ok_s    = (rem_shift_s >= {1'b0, div_q});
   assign rem_next_s  = sub_ok_s ? rem_diff_s[DW-1:0] : rem_shift_s[DW-1:0];

   // Next-state logic: running max, divider sequencing and result load.
   always_comb begin
      state_d   = state_q;
      run_max_d = run_max_q;
      max_lat_d = max_lat_q;
      div_d     = div_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      nf_d      = nf_q;
      fm_d      = fm_q;
      nfv_d     = nfv_q;
      ovr_d     = drop_s;

      if (pixel_tvalid) begin
         run_max_d = pixel_tlast ? {INT_WIDTH{1'b0}} : beat_max_s;
      end else begin
         run_max_d = run_max_q;
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_DIV: begin
            rem_d = rem_next_s;
            quo_d = {quo_q[FRAC_WIDTH-1:0], sub_ok_s};
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(FRAC_WIDTH)) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_DIV;
            end
         end
         S_LOAD: begin
            nf_d    = quo_q[FRAC_WIDTH] ? {FRAC_WIDTH{1'b1}} : quo_q[FRAC_WIDTH-1:0];
            fm_d    = max_lat_q;
            nfv_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // An accepted frame end (IDLE or LOAD) restarts the divider with d = m + 1.
      if (accept_s) begin
         state_d   = S_DIV;
         max_lat_d = beat_max_s;
         div_d     = {1'b0, beat_max_s} + {{(DW-1){1'b0}}, 1'b1};
         rem_d     = {DW{1'b0}};
         quo_d     = {(FRAC_WIDTH+1){1'b0}};
         cnt_d     = {CW{1'b0}};
      end else begin
         max_lat_d = max_lat_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         run_max_q <= {INT_WIDTH{1'b0}};
         max_lat_q <= {INT_WIDTH{1'b0}};
         div_q     <= {DW{1'b0}};
         rem_q     <= {DW{1'b0}};
         quo_q     <= {(FRAC_WIDTH+1){1'b0}};
         cnt_q     <= {CW{1'b0}};
         nf_q      <= {FRAC_WIDTH{1'b0}};
         fm_q      <= {INT_WIDTH{1'b0}};
         nfv_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_max_q <= run_max_d;
         max_lat_q <= max_lat_d;
         div_q     <= div_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         nf_q      <= nf_d;
         fm_q      <= fm_d;
         nfv_q     <= nfv_d;
         ovr_q     <= ovr_d;
      end
   end

`ifdef NORM_FACTOR_GEN_OVERRUN_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   // Saturating count, stepped on the same edge that raises the overrun pulse.
   always_comb begin
      if (drop_s && (ovr_cnt_q != 16'hFFFF)) begin
         ovr_cnt_d = ovr_cnt_q + 16'h0001;
      end else begin
         ovr_cnt_d = ovr_cnt_q;
      end
   end

   // Dropped-frame counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_cnt_q <= 16'h0000;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`else
   assign overrun_count = 16'h0000;
`endif

   assign norm_factor        = nf_q;
   assign norm_factor_tvalid = nfv_q;
   assign frame_max          = fm_q;
   assign overrun            = ovr_q;

endmodule

// File: tb/tb_norm_factor_gen.sv
// Self-checking bench for norm_factor_gen: vector table, directed corner sequences and random frames.
module tb_norm_factor_gen;

   localparam int IW  = 8;
   localparam int FW  = 8;
   localparam int LAT = FW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] pixel;
   logic          pixel_tvalid;
   logic          pixel_tlast;
   logic [FW-1:0] norm_factor;
   logic          norm_factor_tvalid;
   logic [IW-1:0] frame_max;
   logic          overrun;
   logic [15:0]   overrun_count;

   int vectors     = 0;
   int miscompares = 0;
   int exp_ocnt    = 0;

   int cyc_n    = 0;
   int eof_cyc  = -1000;
   int cur_max  = 0;
   int pend_m   = 0;
   bit pending  = 1'b0;

   typedef struct {
      int n;
      int px[4];
      int f;
      int m;
   } vec_t;

   vec_t tbl[8];

   always #5 clk = ~clk;

   norm_factor_gen #(.INT_WIDTH(IW), .FRAC_WIDTH(FW)) dut (
      .clk                (clk),
      .rst                (rst),
      .pixel              (pixel),
      .pixel_tvalid       (pixel_tvalid),
      .pixel_tlast        (pixel_tlast),
      .norm_factor        (norm_factor),
      .norm_factor_tvalid (norm_factor_tvalid),
      .frame_max          (frame_max),
      .overrun            (overrun),
      .overrun_count      (overrun_count)
   );

   function automatic int ref_factor(input int m);
      int q;
      q = (1 << FW) / (m + 1);
      if (q > (1 << FW) - 1) q = (1 << FW) - 1;
      return q;
   endfunction

   function automatic int exp_count();
`ifdef NORM_FACTOR_GEN_OVERRUN_CNT_EN
      return exp_ocnt;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one beat at a falling edge; returns at the next falling edge.
   task automatic cyc(input logic v, input logic l, input int p);
      pixel        = 8'(p);
      pixel_tvalid = v;
      pixel_tlast  = l;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      pixel        = '0;
      pixel_tvalid = 1'b0;
      pixel_tlast  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      exp_ocnt = 0;
   endtask

   task automatic chk_result(input string tag, input int f, input int m);
      chk({tag, "_factor"}, int'(norm_factor), f);
      chk({tag, "_max"}, int'(frame_max), m);
      chk({tag, "_valid"}, int'(norm_factor_tvalid), 1);
   endtask

   // Random-phase beat: tracks the frame max and checks each result LAT edges after its tlast.
   task automatic tick(input logic v, input logic l, input int p);
      int m2;
      cyc(v, l, p);
      cyc_n++;
      if (pending && (cyc_n - eof_cyc == LAT)) begin
         chk("rnd_factor", int'(norm_factor), ref_factor(pend_m));
         chk("rnd_max", int'(frame_max), pend_m);
         chk("rnd_valid", int'(norm_factor_tvalid), 1);
         chk("rnd_product_lt_1", int'(pend_m * int'(norm_factor) < (1 << FW)), 1);
         chk("rnd_no_overrun", int'(overrun), 0);
         pending = 1'b0;
      end
      if (v) begin
         m2 = (p > cur_max) ? p : cur_max;
         if (l) begin
            pend_m  = m2;
            cur_max = 0;
            pending = 1'b1;
            eof_cyc = cyc_n;
         end else begin
            cur_max = m2;
         end
      end
   endtask

   function automatic int rnd_pix();
      if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 255 : 0;
      return int'($urandom_range(0, 255));
   endfunction

   initial begin
      tbl[0] = '{3, '{3, 1, 2, 0},      64,  3};
      tbl[1] = '{2, '{0, 0, 0, 0},      255, 0};
      tbl[2] = '{1, '{255, 0, 0, 0},    1,   255};
      tbl[3] = '{1, '{99, 0, 0, 0},     2,   99};
      tbl[4] = '{3, '{200, 7, 9, 0},    1,   200};
      tbl[5] = '{2, '{1, 0, 0, 0},      128, 1};
      tbl[6] = '{1, '{127, 0, 0, 0},    2,   127};
      tbl[7] = '{4, '{10, 20, 30, 40},  6,   40};

      // Reset state
      rst          = 1'b1;
      pixel        = '0;
      pixel_tvalid = 1'b0;
      pixel_tlast  = 1'b0;
      @(negedge clk);
      chk("rst_factor", int'(norm_factor), 0);
      chk("rst_valid", int'(norm_factor_tvalid), 0);
      chk("rst_max", int'(frame_max), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_count", int'(overrun_count), 0);
      @(negedge clk);
      rst = 1'b0;

      // Latency: factor appears exactly LAT edges after the tlast edge
      cyc(1'b1, 1'b0, 3);
      cyc(1'b1, 1'b0, 1);
      cyc(1'b1, 1'b1, 2);
      idle(LAT - 1);
      chk("lat_not_yet_valid", int'(norm_factor_tvalid), 0);
      idle(1);
      chk_result("lat", 64, 3);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < tbl[i].n; j++) cyc(1'b1, j == tbl[i].n - 1, tbl[i].px[j]);
         idle(LAT);
         chk_result($sformatf("tbl%0d", i), tbl[i].f, tbl[i].m);
         chk($sformatf("tbl%0d_overrun", i), int'(overrun), 0);
      end

      // Overrun: second frame end 4 cycles into DIV is dropped and its max discarded
      do_reset();
      cyc(1'b1, 1'b1, 5);
      idle(3);
      cyc(1'b1, 1'b1, 200);
      exp_ocnt++;
      chk("ovr_pulse", int'(overrun), 1);
      chk("ovr_count", int'(overrun_count), exp_count());
      idle(1);
      chk("ovr_pulse_end", int'(overrun), 0);
      idle(LAT - 5);
      chk_result("ovr_first", ref_factor(5), 5);
      chk("ovr_count_hold", int'(overrun_count), exp_count());
      cyc(1'b1, 1'b1, 2);
      idle(LAT);
      chk_result("ovr_cleared", 85, 2);

      // Back-to-back: frame ends exactly LAT cycles apart
      cyc(1'b1, 1'b1, 3);
      idle(LAT - 1);
      cyc(1'b1, 1'b1, 7);
      chk_result("b2b_first", 64, 3);
      chk("b2b_no_overrun", int'(overrun), 0);
      idle(LAT);
      chk_result("b2b_second", 32, 7);
      chk("b2b_count", int'(overrun_count), exp_count());

      // Asynchronous reset 4 cycles into DIV
      cyc(1'b1, 1'b1, 3);
      idle(4);
      rst = 1'b1;
      #1;
      chk("arst_factor", int'(norm_factor), 0);
      chk("arst_valid", int'(norm_factor_tvalid), 0);
      chk("arst_max", int'(frame_max), 0);
      chk("arst_count", int'(overrun_count), 0);
      @(negedge clk);
      rst      = 1'b0;
      exp_ocnt = 0;
      idle(LAT);
      chk("arst_abandoned", int'(norm_factor_tvalid), 0);
      cyc(1'b1, 1'b1, 15);
      idle(LAT);
      chk_result("arst_after", 16, 15);

      // Random frames, legal spacing, beats of the next frame arriving during DIV/LOAD
      do_reset();
      cyc_n   = 0;
      eof_cyc = -1000;
      cur_max = 0;
      pending = 1'b0;
      for (int f = 0; f < 40; f++) begin
         int n;
         n = int'($urandom_range(1, 6));
         for (int j = 0; j < n - 1; j++) begin
            tick(1'b1, 1'b0, rnd_pix());
            if ($urandom_range(0, 2) == 0) tick(1'b0, 1'b0, rnd_pix());
         end
         while ((cyc_n + 1) - eof_cyc < LAT) tick(1'($urandom_range(0, 1)), 1'b0, rnd_pix());
         tick(1'b1, 1'b1, rnd_pix());
      end
      for (int i = 0; i < LAT; i++) tick(1'b0, 1'b0, 0);
      chk("rnd_all_checked", int'(pending), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/norm_factor_gen.md
# norm_factor_gen

Produces the per-frame normalisation factor consumed by the pixel normaliser (integer pixel × fractional factor → fractional output < 1). The block watches the same unsigned integer pixel stream, tracks each frame's maximum and, at end of frame, computes `norm_factor = floor(2^FRAC_WIDTH / (frame_max + 1))` with a sequential restoring divider. The normaliser's product is therefore always strictly below 1.0. The factor is held as a level with `norm_factor_tvalid` until the next frame's factor replaces it.

## Interface
- `INT_WIDTH`, default 8: pixel width, unsigned integer.
- `FRAC_WIDTH`, default 8: factor width, unsigned fraction (LSB = 2^-FRAC_WIDTH).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `pixel`  in  INT_WIDTH  pixel value.
- `pixel_tvalid`  in  1  pixel beat valid. There is no backpressure.
- `pixel_tlast`  in  1  last beat of frame. Meaningful only with `pixel_tvalid`.
- `norm_factor`  out  FRAC_WIDTH  current factor.
- `norm_factor_tvalid`  out  1  factor valid, held as a level.
- `frame_max`  out  INT_WIDTH  max of the frame that produced `norm_factor`.
- `overrun`  out  1  one-cycle pulse when a frame end is dropped.
- `overrun_count`  out  16  dropped-frame count (see Configuration).

## Operation
- **Running max register `run_max`.** On each valid beat, `run_max <= max(run_max, pixel)`.
  - On a valid tlast beat: `m = max(run_max, pixel)` is the frame max, and `run_max <= 0` for the next frame.
- **Frame-end acceptance.** A tlast beat is accepted only when the FSM is in IDLE or LOAD.
  - On acceptance: `m` is latched, the divisor `d = m + 1` (INT_WIDTH+1 bits) is loaded, and the FSM enters DIV.
  - Otherwise the frame end is dropped: `overrun` pulses and `run_max` still clears.
- **FSM states:** IDLE, DIV, LOAD.
  - IDLE: wait for an accepted tlast beat, then go to DIV.
  - DIV: restoring division of dividend `2^FRAC_WIDTH` by `d`.
    - Produces one quotient bit per cycle, MSB first.
    - Runs exactly FRAC_WIDTH+1 cycles, producing a FRAC_WIDTH+1-bit quotient `q`, then goes to LOAD.
  - LOAD: register the result.
    - `norm_factor <= (q >= 2^FRAC_WIDTH) ? 2^FRAC_WIDTH-1 : q`. The only saturating case is m = 0.
    - `frame_max <=` latched m; `norm_factor_tvalid <= 1`.
    - Next state: DIV if a tlast beat is accepted this cycle, else IDLE.
- **Non-frame beats.** Pixels of the following frame keep accumulating into `run_max` during DIV and LOAD.
- **Validity.** `norm_factor_tvalid` stays 1 once set; it returns to 0 only on reset. `norm_factor` changes only in LOAD.
- **Size limit.** If FRAC_WIDTH < INT_WIDTH, the factor may be 0 for large maxima. This is legal, not an error.

## Timing
- **Reset values.** All outputs are 0, the FSM is in IDLE, and `run_max` = 0.
- **Reset mid-DIV or mid-LOAD.** The computation is abandoned and the outputs return to 0 asynchronously.
  - The first factor after reset requires a new complete frame end.
- **Latency.** A tlast beat sampled at edge E0 sets DIV at E0.
  - DIV occupies the cycles ending at edges E1..E(FRAC_WIDTH+1).
  - LOAD writes the outputs at edge E(FRAC_WIDTH+2), so the new factor is visible FRAC_WIDTH+2 cycles after E0.
- **Minimum frame spacing.** Frame ends must be at least FRAC_WIDTH+2 cycles apart.
  - A tlast landing exactly on the LOAD cycle is accepted, giving back-to-back operation.
- **Overrun timing.** `overrun` is asserted in the cycle after the dropped tlast edge and lasts one cycle.
- **Single-beat frame.** A tlast beat with no prior beats in the frame gives m = pixel.

## Configuration
- Macro: `NORM_FACTOR_GEN_OVERRUN_CNT_EN`.
- **Defined:** `overrun_count` increments on each `overrun` pulse. It saturates at 16'hFFFF and is cleared only by `rst`.
- **Undefined:** no counter logic is built, and `overrun_count` is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use INT_WIDTH=8 and FRAC_WIDTH=8.
- Frame {3,1,2} with tlast on 2 → after FRAC_WIDTH+2 = 10 cycles, `norm_factor`=64 (256/4), `frame_max`=3, `norm_factor_tvalid`=1.
- Frame {0,0} → `norm_factor`=255 (saturated 256/1); frame {255} → `norm_factor`=1; frame {99} → `norm_factor`=2.
- Two frame ends 4 cycles apart → the second is dropped and `overrun` pulses once. `norm_factor` reflects only the first frame. `overrun_count`=1 with the macro defined, 0 without it.
- Frame ends exactly 10 cycles apart with maxima 3 then 7 → factors 64 then 32. No overrun.
- Assert `rst` 4 cycles into DIV → all outputs 0 immediately. A following frame {15} yields `norm_factor`=16.
- Random frames → feed the factor to a pixel × factor multiplier. Every pixel × `norm_factor` is < 256, i.e. the fractional result is < 1.
